// File: rtl/apple_placer.sv
// Picks a pseudo-random free cell on a W x H LED playfield for a new apple.
// Starts at an LFSR-derived candidate and probes one cell per cycle, wrapping once around the field.
module apple_placer #(
  parameter int          W     = 16,
  parameter int          H     = 16,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          RST_X = 12,
  parameter int          RST_Y = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [H-1:0][W-1:0]    RedPixels,
  input  logic [H-1:0][W-1:0]    GrnPixels,
  input  logic                   req,
  output logic                   busy,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(H)-1:0]   x,
  output logic [$clog2(W)-1:0]   y
);

  localparam int unsigned NCELLS  = W * H;
  localparam int          IW      = $clog2(W * H);
  localparam int          XW      = $clog2(H);
  localparam int          YW      = $clog2(W);
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [IW-1:0] LAST  = IW'(NCELLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE, NOFREE} state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [XW-1:0]   row;
  logic [YW-1:0]   col;
  logic [IW-1:0]   count;
  int unsigned     cand;
  logic [XW-1:0]   cand_row;
  logic [YW-1:0]   cand_col;
  logic            cell_free;

  // Fibonacci form, taps 16,14,13,11 (bits 0,2,3,5 feeding the top bit).
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  assign cell_free = ~(RedPixels[row][col] | GrnPixels[row][col]);

  // The only division is by the constant W on the start candidate; during the
  // scan the row/column pair is stepped incrementally instead.
  // NOTE: every variable in always_comb is assigned before any conditional use, so no latch is inferred.
  always_comb begin
    cand = 32'(lfsr[IW-1:0]);
    if (cand >= NCELLS) cand = cand - NCELLS;
    cand_row = XW'(cand / W);
    cand_col = YW'(cand % W);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      full  <= 1'b0;
      x     <= XW'(RST_X);
      y     <= YW'(RST_Y);
      lfsr  <= SEED_NZ;
      row   <= '0;
      col   <= '0;
      count <= '0;
    end else begin
      lfsr  <= lfsr_next;
      valid <= 1'b0;
      full  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state <= SCAN;
            busy  <= 1'b1;
            row   <= cand_row;
            col   <= cand_col;
            count <= '0;
          end
        end
        SCAN: begin
          if (cell_free) begin
            x     <= row;
            y     <= col;
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else if (count == LAST) begin
            state <= NOFREE;
            busy  <= 1'b0;
            full  <= 1'b1;
          end else begin
            count <= count + 1'b1;
            // Row-major step with wrap from the last cell back to [0][0].
            if (col == YW'(W - 1)) begin
              col <= '0;
              row <= (row == XW'(H - 1)) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE:   state <= IDLE;
        NOFREE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apple_placer.md
APPLE_PLACER -- requirements
Module: apple_placer

Interface
REQ-001 Parameter W, default 16, playfield columns (2..256).
REQ-002 Parameter H, default 16, playfield rows (2..256); W*H SHALL be <= 65536.
REQ-003 Parameter SEED, default 16'hACE1, LFSR reset value; 0 SHALL be replaced by 16'h0001.
REQ-004 Parameter RST_X, default 12, reset row; RST_Y, default 12, reset column (each < H / < W).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-007 RedPixels  input  [H-1:0][W-1:0]  red LED plane, indexed [row][col].
REQ-008 GrnPixels  input  [H-1:0][W-1:0]  green LED plane, indexed [row][col].
REQ-009 req  input  1  single-cycle request for a new apple location.
REQ-010 busy  output  1  high while a search is in progress.
REQ-011 valid  output  1  one-cycle pulse: x,y hold a newly found free cell.
REQ-012 full  output  1  one-cycle pulse: search found no free cell.
REQ-013 x  output  clog2(H)  apple row; y  output  clog2(W)  apple column.

Function
REQ-014 A cell SHALL be free iff RedPixels[r][c]==0 and GrnPixels[r][c]==0.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle when not in reset.
REQ-016 Linear index SHALL be idx = r*W + c, IW = clog2(W*H) bits, row-major.
REQ-017 Candidate SHALL be lfsr[IW-1:0], minus W*H once if >= W*H (always < W*H).
REQ-018 FSM states SHALL be IDLE, SCAN, DONE, NOFREE.
REQ-019 IDLE: req==1 at edge N -> SCAN at N+1, idx=candidate, probe count=0, busy=1.
REQ-020 req SHALL be ignored in every state except IDLE.
REQ-021 SCAN: each cycle probes cell idx using live pixel inputs that cycle (one probe per cycle).
REQ-022 SCAN, probed cell free -> latch x=idx/W, y=idx%W, go DONE.
REQ-023 SCAN, probed cell occupied -> idx=idx+1, wrapping W*H-1 -> 0; count+1.
REQ-024 SCAN, count reaches W*H-1 with probed cell occupied -> go NOFREE; x,y unchanged.
REQ-025 DONE: valid=1, busy=0 for exactly one cycle, then IDLE.
REQ-026 NOFREE: full=1, busy=0 for exactly one cycle, then IDLE.
REQ-027 Latency: free candidate -> valid at N+2; k occupied probes first -> valid at N+2+k.
REQ-028 All-occupied field -> full at N+1+W*H.
REQ-029 x,y SHALL hold their last value between results; valid and full SHALL never be high together.
REQ-030 x,y SHALL be registered, never combinational from pixel inputs.
REQ-031 Division/modulo by W SHALL avoid runtime dividers (row/col counters tracked alongside idx).
REQ-032 Behaviour SHALL be correct for non-power-of-two W and H.

Reset
REQ-033 reset==0 at an edge -> state IDLE, busy=0, valid=0, full=0, x=RST_X, y=RST_Y, lfsr=SEED.
REQ-034 reset mid-SCAN SHALL abort the search with no valid/full pulse.
REQ-035 req coincident with reset SHALL be dropped.

Verification
REQ-036 W=H=16, planes all 0, req at N -> valid at N+2, x*16+y equals candidate, busy high at N+1 only.
REQ-037 W=H=16, all cells red, req at N -> busy N+1..N+256, full at N+257, x=12,y=12 unchanged.
REQ-038 W=H=16, all occupied except [0][0] -> valid with x=0,y=0 (wrap path exercised), latency <= 257.
REQ-039 req pulsed again during SCAN -> ignored; exactly one valid per accepted req.
REQ-040 reset=0 at SCAN cycle 3 of full-field search -> no full pulse; outputs at reset values next cycle.
REQ-041 W=10, H=12, 1000 random requests on random occupancy -> every result x<12, y<10, cell free in probe cycle.
